// File: rtl/serial_msg_pkg.sv
// rtl/serial_msg_pkg.sv - shared state encoding and default header for the serial message transmitter/receiver
package serial_msg_pkg;

  localparam int HDR_MAX_BYTES = 16;

  // The header parameter is right-justified, so shorter strings are zero-padded on the left.
  localparam logic [8*HDR_MAX_BYTES-1:0] DEFAULT_START_MESSAGE = "KLMNO";

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_HEADER    = 3'd1;
  localparam logic [2:0] ST_PAYLOAD   = 3'd2;
  localparam logic [2:0] ST_CHECKSUM  = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;

endpackage

// File: rtl/serial_msg_transmitter_if.sv
// rtl/serial_msg_transmitter_if.sv - byte link between the frame transmitter and serial_tx
interface serial_msg_transmitter_if;

  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_done;

  modport master (output tx_data, output tx_data_valid, input tx_done);
  modport slave  (input tx_data, input tx_data_valid, output tx_done);

endinterface

// File: rtl/serial_msg_transmitter.sv
// rtl/serial_msg_transmitter.sv - frames header, payload and optional XOR checksum into
// one byte strobe at a time, waiting for serial_tx to finish each byte.
module serial_msg_transmitter
  import serial_msg_pkg::*;
#(
  parameter logic [8*HDR_MAX_BYTES-1:0] START_MESSAGE             = DEFAULT_START_MESSAGE,
  parameter int                         START_MESSAGE_LENGTH_BYTE = 5,
  parameter int                         PAYLOAD_LENGTH            = 8,
  parameter bit                         CHECKSUM_EN               = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [PAYLOAD_LENGTH*8-1:0]   payload_in,
  input  logic                          send,
  output logic                          busy,
  output logic                          frame_done,
  serial_msg_transmitter_if.master      tx
);

  localparam int MAX_LEN = (START_MESSAGE_LENGTH_BYTE > PAYLOAD_LENGTH) ?
                           START_MESSAGE_LENGTH_BYTE : PAYLOAD_LENGTH;
  localparam int IDX_W   = $clog2(MAX_LEN + 1);

  localparam logic [IDX_W-1:0] HDR_LAST = IDX_W'(START_MESSAGE_LENGTH_BYTE - 1);
  localparam logic [IDX_W-1:0] PAY_LAST = IDX_W'(PAYLOAD_LENGTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [2:0]                  state;
  logic [2:0]                  resume_state;
  logic [IDX_W-1:0]            idx;
  logic [PAYLOAD_LENGTH*8-1:0] payload_q;
  logic [7:0]                  checksum;

  // Byte i counted from the most-significant end, so index 0 goes out first.
  function automatic logic [7:0] hdr_byte(input logic [IDX_W-1:0] i);
    logic [8*HDR_MAX_BYTES-1:0] sh;
    sh = START_MESSAGE >> (8 * (START_MESSAGE_LENGTH_BYTE - 1 - int'(i)));
    return sh[7:0];
  endfunction

  function automatic logic [7:0] pay_byte(input logic [PAYLOAD_LENGTH*8-1:0] p,
                                          input logic [IDX_W-1:0]            i);
    logic [PAYLOAD_LENGTH*8-1:0] sh;
    sh = p >> (8 * (PAYLOAD_LENGTH - 1 - int'(i)));
    return sh[7:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      resume_state     <= ST_IDLE;
      idx              <= '0;
      payload_q        <= '0;
      checksum         <= '0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      tx.tx_data       <= '0;
      tx.tx_data_valid <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (send) begin
            payload_q        <= payload_in;
            checksum         <= '0;
            busy             <= 1'b1;
            idx              <= '0;
            state            <= ST_HEADER;
            tx.tx_data       <= hdr_byte('0);
            tx.tx_data_valid <= 1'b1;
          end
        end

        // Strobe states: valid was raised on entry and lasts exactly this one cycle.
        ST_HEADER, ST_PAYLOAD, ST_CHECKSUM: begin
          tx.tx_data_valid <= 1'b0;
          resume_state     <= state;
          state            <= ST_WAIT_DONE;
        end

        ST_WAIT_DONE: begin
          if (tx.tx_done) begin
            case (resume_state)
              ST_HEADER: begin
                tx.tx_data_valid <= 1'b1;
                if (idx == HDR_LAST) begin
                  idx        <= '0;
                  state      <= ST_PAYLOAD;
                  tx.tx_data <= pay_byte(payload_q, '0);
                  checksum   <= checksum ^ pay_byte(payload_q, '0);
                end else begin
                  idx        <= idx + IDX_ONE;
                  state      <= ST_HEADER;
                  tx.tx_data <= hdr_byte(idx + IDX_ONE);
                end
              end

              ST_PAYLOAD: begin
                if (idx != PAY_LAST) begin
                  idx              <= idx + IDX_ONE;
                  state            <= ST_PAYLOAD;
                  tx.tx_data       <= pay_byte(payload_q, idx + IDX_ONE);
                  tx.tx_data_valid <= 1'b1;
                  checksum         <= checksum ^ pay_byte(payload_q, idx + IDX_ONE);
                end else if (CHECKSUM_EN) begin
                  idx              <= '0;
                  state            <= ST_CHECKSUM;
                  tx.tx_data       <= checksum;
                  tx.tx_data_valid <= 1'b1;
                end else begin
                  idx        <= '0;
                  state      <= ST_IDLE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                end
              end

              default: begin
                idx        <= '0;
                state      <= ST_IDLE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
              end
            endcase
          end
        end

        default: begin
          state            <= ST_IDLE;
          busy             <= 1'b0;
          tx.tx_data_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_msg_transmitter.sv
// tb/tb_serial_msg_transmitter.sv - scoreboard bench for serial_msg_transmitter with and without checksum
module tb_serial_msg_transmitter;

  localparam logic [127:0] HDR = "KLM";

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] payload_a = '0, payload_b = '0;
  logic        send_a = 1'b0, send_b = 1'b0;
  logic        busy_a, busy_b, fd_a, fd_b;

  always #5 clk = ~clk;

  serial_msg_transmitter_if tx_a ();
  serial_msg_transmitter_if tx_b ();

  serial_msg_transmitter #(
    .START_MESSAGE(HDR), .START_MESSAGE_LENGTH_BYTE(3), .PAYLOAD_LENGTH(4), .CHECKSUM_EN(1'b1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .payload_in(payload_a), .send(send_a),
    .busy(busy_a), .frame_done(fd_a), .tx(tx_a)
  );

  serial_msg_transmitter #(
    .START_MESSAGE(HDR), .START_MESSAGE_LENGTH_BYTE(3), .PAYLOAD_LENGTH(4), .CHECKSUM_EN(1'b0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .payload_in(payload_b), .send(send_b),
    .busy(busy_b), .frame_done(fd_b), .tx(tx_b)
  );

  int checks = 0, errors = 0;
  logic [7:0] q_a[$], q_b[$];
  int strb_a = 0, strb_b = 0, frames_a = 0, frames_b = 0;
  int cnt_a = 0, cnt_b = 0;
  bit spur_a = 1'b0, spur_idle_a = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected frame: header K L M, payload MSB first, then XOR of payload bytes if enabled.
  task automatic push_frame(input bit to_b, input logic [31:0] p);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    for (int i = 0; i < 3; i++) begin
      b = HDR[8*(2-i) +: 8];
      if (to_b) q_b.push_back(b); else q_a.push_back(b);
    end
    for (int i = 0; i < 4; i++) begin
      b = p[8*(3-i) +: 8];
      x = x ^ b;
      if (to_b) q_b.push_back(b); else q_a.push_back(b);
    end
    if (!to_b) q_a.push_back(x);
  endtask

  // serial_tx stand-in: tx_done returns 10 cycles after each strobe.
  initial begin
    tx_a.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_a.tx_done = 1'b0;
      if (!reset_n) cnt_a = 0;
      else begin
        if (cnt_a > 0) begin
          cnt_a--;
          if (cnt_a == 0) tx_a.tx_done = 1'b1;
        end
        if (tx_a.tx_data_valid) begin
          cnt_a = 10;
          if (spur_a) tx_a.tx_done = 1'b1;
        end
      end
      if (spur_idle_a) tx_a.tx_done = 1'b1;
    end
  end

  initial begin
    tx_b.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_b.tx_done = 1'b0;
      if (!reset_n) cnt_b = 0;
      else begin
        if (cnt_b > 0) begin
          cnt_b--;
          if (cnt_b == 0) tx_b.tx_done = 1'b1;
        end
        if (tx_b.tx_data_valid) cnt_b = 10;
      end
    end
  end

  always @(negedge clk) begin
    if (tx_a.tx_data_valid) begin
      strb_a++;
      chk("a_busy_in_frame", busy_a, 1);
      chk("a_strobe_expected", q_a.size() != 0, 1);
      if (q_a.size() != 0) chk("a_byte", tx_a.tx_data, q_a.pop_front());
    end
    if (fd_a) begin
      frames_a++;
      chk("a_busy_low_at_done", busy_a, 0);
    end
    if (tx_b.tx_data_valid) begin
      strb_b++;
      chk("b_strobe_expected", q_b.size() != 0, 1);
      if (q_b.size() != 0) chk("b_byte", tx_b.tx_data, q_b.pop_front());
    end
    if (fd_b) begin
      frames_b++;
      chk("b_busy_low_at_done", busy_b, 0);
    end
  end

  task automatic pulse_send(input bit b, input logic [31:0] p, input bit expect_start);
    @(negedge clk);
    if (b) begin payload_b = p; send_b = 1'b1; end
    else   begin payload_a = p; send_a = 1'b1; end
    @(negedge clk);
    send_a = 1'b0;
    send_b = 1'b0;
    if (expect_start)
      chk(b ? "b_start_latency" : "a_start_latency",
          b ? tx_b.tx_data_valid : tx_a.tx_data_valid, 1);
  endtask

  task automatic wait_frames(input bit b, input int n);
    for (int i = 0; i < 2000 && (b ? frames_b : frames_a) < n; i++) begin
      @(negedge clk);
      #1;
    end
    chk(b ? "b_frame_count" : "a_frame_count", b ? frames_b : frames_a, n);
  endtask

  task automatic wait_strobes_a(input int n);
    for (int i = 0; i < 1000 && strb_a < n; i++) begin
      @(negedge clk);
      #1;
    end
    chk("a_strobe_reached", strb_a >= n, 1);
  endtask

  int base;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx_data", tx_a.tx_data, 0);
    chk("rst_valid", tx_a.tx_data_valid, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_frame_done", fd_a, 0);
    reset_n = 1'b1;

    // tx_done while idle must not start or advance anything
    @(negedge clk);
    spur_idle_a = 1'b1;
    repeat (2) @(negedge clk);
    spur_idle_a = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_tx_done_strobes", strb_a, 0);
    chk("idle_tx_done_busy", busy_a, 0);

    // basic frame with checksum
    push_frame(1'b0, 32'h01020304);
    pulse_send(1'b0, 32'h01020304, 1'b1);
    wait_frames(1'b0, 1);

    // same frame with tx_done also hitting every strobe cycle
    spur_a = 1'b1;
    push_frame(1'b0, 32'h01020304);
    pulse_send(1'b0, 32'h01020304, 1'b1);
    wait_frames(1'b0, 2);
    spur_a = 1'b0;

    // no checksum trailer
    push_frame(1'b1, 32'hAABBCCDD);
    pulse_send(1'b1, 32'hAABBCCDD, 1'b1);
    wait_frames(1'b1, 1);
    chk("b_strobe_count", strb_b, 7);
    chk("b_last_byte_held", tx_b.tx_data, 8'hDD);

    // sends during an active frame are ignored
    base = strb_a;
    push_frame(1'b0, 32'h12345678);
    pulse_send(1'b0, 32'h12345678, 1'b1);
    wait_strobes_a(base + 2);
    pulse_send(1'b0, 32'hDEADBEEF, 1'b0);
    wait_strobes_a(base + 5);
    pulse_send(1'b0, 32'hDEADBEEF, 1'b0);
    wait_frames(1'b0, 3);
    repeat (40) @(negedge clk);
    #1;
    chk("busy_send_frames", frames_a, 3);
    chk("busy_send_strobes", strb_a - base, 8);

    // send accepted in the frame_done cycle
    push_frame(1'b0, 32'h01020304);
    push_frame(1'b0, 32'hFFFFFFFF);
    pulse_send(1'b0, 32'h01020304, 1'b1);
    for (int i = 0; i < 400 && !fd_a; i++) @(negedge clk);
    chk("b2b_first_done", fd_a, 1);
    payload_a = 32'hFFFFFFFF;
    send_a = 1'b1;
    @(negedge clk);
    send_a = 1'b0;
    chk("b2b_start_latency", tx_a.tx_data_valid, 1);
    wait_frames(1'b0, 5);

    // reset while waiting on the first payload byte
    base = strb_a;
    q_a.push_back(8'h4B); q_a.push_back(8'h4C); q_a.push_back(8'h4D); q_a.push_back(8'h01);
    pulse_send(1'b0, 32'h01020304, 1'b1);
    wait_strobes_a(base + 4);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_tx_data", tx_a.tx_data, 0);
    chk("midrst_valid", tx_a.tx_data_valid, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_frame_done", fd_a, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    chk("midrst_no_strobe", strb_a - base, 4);
    chk("midrst_no_frame", frames_a, 5);
    push_frame(1'b0, 32'h01020304);
    pulse_send(1'b0, 32'h01020304, 1'b1);
    wait_frames(1'b0, 6);

    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
